// File: rtl/fetch_decode_queue_pkg.sv
// Shared definitions for the fetch/decode instruction queue.
package fetch_decode_queue_pkg;

  localparam int INSTR_W = 32;
  localparam int PC_W    = 32;
  localparam logic [31:0] NOP_INSTR = 32'b0;

  // Ceiling log2, never below 1 so a width derived from it is always legal.
  function automatic int fdq_clog2(input int v);
    int r;
    r = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fetch_decode_queue_mem.sv
// Entry storage: DEPTH x W registers, one synchronous write port and one
// combinational read port. Contents are deliberately not reset.
module fetch_decode_queue_mem #(
  parameter int DEPTH = 4,
  parameter int W     = 64,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  // Write the selected entry on a qualified push.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_decode_queue.sv
// Instruction queue between fetch and decode. Buffers {pc, instr} pairs in
// FIFO order, drops everything on a redirect flush, no bypass path.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in_ready depends only on count (a pop never frees a slot in the
// same cycle); out_valid depends only on count; payloads are held stable
// while valid is high and not accepted.
module fetch_decode_queue #(
  parameter int DEPTH   = 4,
  parameter int INSTR_W = fetch_decode_queue_pkg::INSTR_W,
  parameter int PC_W    = fetch_decode_queue_pkg::PC_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [PC_W-1:0]    in_pc,
  output logic               in_ready,
  input  logic               flush,
  output logic               out_valid,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc,
  input  logic               out_ready,
  output logic [fetch_decode_queue_pkg::fdq_clog2(DEPTH+1)-1:0] count
);

  import fetch_decode_queue_pkg::*;

  localparam int PTR_W = fdq_clog2(DEPTH);
  localparam int CNT_W = fdq_clog2(DEPTH + 1);
  localparam int ENT_W = PC_W + INSTR_W;

  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [PTR_W-1:0] rd_ptr_nxt, wr_ptr_nxt;
  logic             push, pop;
  logic [ENT_W-1:0] head;

  assign in_ready  = (count < CNT_W'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  assign wr_ptr_nxt = (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
  assign rd_ptr_nxt = (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;

  // A push in a flush or reset cycle is discarded, so do not write storage.
  fetch_decode_queue_mem #(
    .DEPTH (DEPTH),
    .W     (ENT_W),
    .AW    (PTR_W)
  ) u_mem (
    .clk   (clk),
    .we    (push & ~flush & ~rst),
    .waddr (wr_ptr),
    .wdata ({in_pc, in_instr}),
    .raddr (rd_ptr),
    .rdata (head)
  );

  // Empty queue presents a NOP at pc 0 rather than stale storage.
  assign out_instr = out_valid ? head[INSTR_W-1:0] : INSTR_W'(NOP_INSTR);
  assign out_pc    = out_valid ? head[ENT_W-1:INSTR_W] : '0;

  // Pointer and occupancy update; reset beats flush, flush beats push/pop.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr_nxt;
      if (pop)  rd_ptr <= rd_ptr_nxt;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Directed bench for fetch_decode_queue: hand-computed checks per scenario
// plus an expected-entry queue for FIFO ordering.
module tb_fetch_decode_queue;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        in_ready;
  logic        flush;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_ready;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  // Expected entries {pc, instr}, head at index 0.
  logic [63:0] exp_q[$];

  fetch_decode_queue dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_instr  (in_instr),
    .in_pc     (in_pc),
    .in_ready  (in_ready),
    .flush     (flush),
    .out_valid (out_valid),
    .out_instr (out_instr),
    .out_pc    (out_pc),
    .out_ready (out_ready),
    .count     (count)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; sampling happens 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return 32'hA0 + pc;
  endfunction

  // One cycle of stimulus; scoreboard predicts handshakes from its own queue.
  task automatic cycle(input logic iv, input logic [31:0] pc, input logic ordy, input logic fl);
    bit push_m, pop_m;
    in_valid  = iv;
    in_pc     = pc;
    in_instr  = instr_of(pc);
    out_ready = ordy;
    flush     = fl;
    #1;
    push_m = iv && (exp_q.size() < 4);
    pop_m  = ordy && (exp_q.size() > 0);
    check("sb_in_ready", {63'd0, in_ready}, {63'd0, exp_q.size() < 4});
    check("sb_out_valid", {63'd0, out_valid}, {63'd0, exp_q.size() > 0});
    if (pop_m) check("sb_head", {out_pc, out_instr}, exp_q[0]);
    if (fl) begin
      exp_q.delete();
    end else begin
      if (pop_m) void'(exp_q.pop_front());
      if (push_m) exp_q.push_back({pc, instr_of(pc)});
    end
    step();
    check("sb_count", {61'd0, count}, 64'(exp_q.size()));
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
  endtask

  // Reset for n cycles, optionally with flush also high.
  task automatic do_reset(input int n, input logic fl);
    rst   = 1'b1;
    flush = fl;
    for (int i = 0; i < n; i++) step();
    rst   = 1'b0;
    flush = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0;
    flush = 1'b0; out_ready = 1'b0;
    #2;

    // 1: reset then idle
    do_reset(2, 1'b0);
    step();
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_count", {61'd0, count}, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_out_instr", {32'd0, out_instr}, 64'd0);
    check("rst_out_pc", {32'd0, out_pc}, 64'd0);

    // 2: fill, overflow push dropped, drain in order
    for (int i = 0; i < 4; i++) cycle(1'b1, 32'(i), 1'b0, 1'b0);
    check("t2_full_count", {61'd0, count}, 64'd4);
    check("t2_full_in_ready", {63'd0, in_ready}, 64'd0);
    check("t2_head_instr", {32'd0, out_instr}, 64'hA0);
    cycle(1'b1, 32'd4, 1'b0, 1'b0);
    check("t2_drop_count", {61'd0, count}, 64'd4);
    for (int i = 0; i < 4; i++) begin
      check("t2_drain_pc", {32'd0, out_pc}, 64'(i));
      cycle(1'b0, 32'd0, 1'b1, 1'b0);
    end
    check("t2_empty_valid", {63'd0, out_valid}, 64'd0);
    check("t2_empty_instr", {32'd0, out_instr}, 64'd0);
    check("t2_empty_pc", {32'd0, out_pc}, 64'd0);
    cycle(1'b0, 32'd0, 1'b1, 1'b0);
    check("t2_pop_empty_count", {61'd0, count}, 64'd0);

    // 3: steady push+pop at count 2, pointers wrap
    cycle(1'b1, 32'h10, 1'b0, 1'b0);
    cycle(1'b1, 32'h11, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      check("t3_pc_seq", {32'd0, out_pc}, 64'(32'h10 + i));
      cycle(1'b1, 32'(32'h12 + i), 1'b1, 1'b0);
      check("t3_count", {61'd0, count}, 64'd2);
    end
    check("t3_head_after", {32'd0, out_pc}, 64'h1A);

    // 4: flush at count 3 with push and pop asserted
    cycle(1'b1, 32'h1C, 1'b0, 1'b0);
    check("t4_pre_count", {61'd0, count}, 64'd3);
    cycle(1'b1, 32'h1D, 1'b1, 1'b1);
    check("t4_flush_count", {61'd0, count}, 64'd0);
    check("t4_flush_valid", {63'd0, out_valid}, 64'd0);
    cycle(1'b1, 32'h30, 1'b0, 1'b0);
    check("t4_new_head", {32'd0, out_pc}, 64'h30);
    cycle(1'b0, 32'd0, 1'b1, 1'b0);
    check("t4_empty_after", {63'd0, out_valid}, 64'd0);

    // 5: full with pop and push: pop happens, push refused
    for (int i = 0; i < 4; i++) cycle(1'b1, 32'(32'h31 + i), 1'b0, 1'b0);
    cycle(1'b1, 32'h35, 1'b1, 1'b0);
    check("t5_count", {61'd0, count}, 64'd3);
    check("t5_in_ready", {63'd0, in_ready}, 64'd1);
    check("t5_head", {32'd0, out_pc}, 64'h32);

    // 6: reset together with flush at count 2
    cycle(1'b0, 32'd0, 1'b1, 1'b0);
    check("t6_pre_count", {61'd0, count}, 64'd2);
    in_valid = 1'b1; in_pc = 32'h50; in_instr = instr_of(32'h50); out_ready = 1'b1;
    do_reset(1, 1'b1);
    in_valid = 1'b0; out_ready = 1'b0;
    check("t6_rst_count", {61'd0, count}, 64'd0);
    check("t6_rst_valid", {63'd0, out_valid}, 64'd0);
    check("t6_rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("t6_rst_pc", {32'd0, out_pc}, 64'd0);
    cycle(1'b1, 32'h40, 1'b0, 1'b0);
    check("t6_push_pc", {32'd0, out_pc}, 64'h40);
    check("t6_push_instr", {32'd0, out_instr}, 64'hE0);
    check("t6_push_count", {61'd0, count}, 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
